// File: rtl/piso_pkg.sv
// ---------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in/serial-out serializer:
//   - state_t       : FSM state encoding (IDLE, SHIFT)
//   - DEFAULT_WIDTH : default word length
//   - cnt_width(w)  : bit counter width needed to count 0..w
// ---------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // The counter has to hold values 0..w, so it needs clog2(w+1) bits.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// ---------------------------------------------------------------------------
// piso_bit_counter
// Loadable up-counter that tracks how many bits of the current word have
// been consumed. It has no wrap logic because it is cleared on every load.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   i_clear    in   force the count to zero (word load)
//   i_inc      in   advance the count by one (bit consumed)
//   o_count    out  current count
//   o_terminal out  high when the count equals WIDTH-1 (final bit pending)
// ---------------------------------------------------------------------------
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   input  logic          i_inc,
   output logic [CW-1:0] o_count,
   output logic          o_terminal
);

   logic [CW-1:0] r_count;

   // Clear has priority over increment so a load always starts counting at 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word through a
// valid/ready handshake while idle, then shifts it out one bit per enabled
// cycle. The receiver shares the shift strobe through shift_en_out.
// Ports:
//   clk          in   system clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   en           in   shift strobe, one bit consumed per enabled busy cycle
//   data_in      in   word to transmit, sampled on the load handshake
//   load_valid   in   producer has a word on data_in
//   load_ready   out  block can accept a word (IDLE only)
//   serial_out   out  current transmitted bit
//   shift_en_out out  busy & en, drives the receiver's enable
//   busy         out  high while in SHIFT
//   done         out  registered one-cycle pulse after the last bit is consumed
// ---------------------------------------------------------------------------
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             shift_en_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_shreg;
   logic             r_done;
   logic             w_loadAccept;
   logic             w_consume;
   logic             w_lastBit;
   logic [CW-1:0]    w_count;

   assign w_loadAccept = load_valid && (r_state == IDLE);
   assign w_consume    = en && (r_state == SHIFT);

   piso_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_loadAccept),
      .i_inc      (w_consume),
      .o_count    (w_count),
      .o_terminal (w_lastBit)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: a word moves us to SHIFT, the final consumed bit
   // returns us to IDLE. Any unexpected encoding recovers to IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_loadAccept) w_nextState = SHIFT;
         SHIFT:   if (w_consume && w_lastBit) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Shift register: captures on load, shifts toward the output end with
   // zero-fill on each consume. After the last bit it is all zeros, which
   // keeps serial_out low while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shreg <= '0;
      end else if (w_loadAccept) begin
         r_shreg <= data_in;
      end else if (w_consume) begin
         if (LSB_FIRST != 0) begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
         end else begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Done pulse: registered so it appears in the cycle after the final consume.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_consume && w_lastBit;
      end
   end

   // Output decode from the current state and shift register.
   always_comb begin
      load_ready   = (r_state == IDLE);
      busy         = (r_state == SHIFT);
      shift_en_out = (r_state == SHIFT) && en;
      serial_out   = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[WIDTH-1];
      done         = r_done;
   end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter that serialises one WIDTH-bit word onto a single wire, paired with the existing 8-bit shift-right deserializer, Shift_Registers.
- Bit order is LSB first, so after WIDTH enabled shifts the receiver's Q equals the loaded word.
- Sits between a byte producer, which uses a valid/ready load handshake, and the serial link.
- Shares the shift-enable strobe with the receiver.

Parameters:
WIDTH, 8, word length in bits (legal range 2..32).
LSB_FIRST, 1, 1 = shift out bit 0 first; 0 = bit WIDTH-1 first.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
en  in  1  shift strobe; one bit is consumed per cycle en=1 while busy.
data_in  in  WIDTH  word to transmit; sampled only on load handshake.
load_valid  in  1  producer has a word on data_in.
load_ready  out  1  block can accept a word (high only in IDLE).
serial_out  out  1  current transmitted bit; drives receiver serial_in.
shift_en_out  out  1  = busy & en; drives receiver en.
busy  out  1  high in SHIFT state.
done  out  1  registered one-cycle pulse after the final bit is consumed.

Behaviour:
- Reset (sync, active-high) forces state IDLE, shift register 0, bit counter 0, done 0.
- Resulting outputs after reset: serial_out 0, busy 0, load_ready 1, shift_en_out 0.
- Reset mid-word aborts the transfer with no done pulse. Reset dominates load and en in the same cycle.
- States: IDLE, SHIFT. Encoded as an enum; the illegal/default state goes to IDLE.
- IDLE:
  - load_ready=1.
  - On load_valid & load_ready at edge N: shreg<=data_in, cnt<=0, state<=SHIFT.
  - en is ignored in IDLE.
- SHIFT:
  - load_ready=0; load_valid is ignored, with no capture and no error.
  - serial_out is combinational from shreg: shreg[0] if LSB_FIRST, else shreg[WIDTH-1].
  - When en=1 at an edge:
    - Shift shreg toward the output end, zero-filling.
    - cnt<=cnt+1.
    - If cnt==WIDTH-1: state<=IDLE and done<=1 next cycle.
  - When en=0, all state is held and serial_out is stable.
- Latency:
  - Load accepted at edge N makes bit 0 visible in cycle N+1.
  - With en held high, the last bit is consumed at edge N+WIDTH.
  - done=1 and load_ready=1 during cycle N+WIDTH+1.
  - Back-to-back: a new load is accepted at edge N+WIDTH+1, giving a minimum inter-word period of WIDTH+1 cycles.
- Zero-fill means serial_out=0 whenever IDLE after a completed word.
- The counter is $clog2(WIDTH+1) bits wide and never wraps: it resets to 0 on each load.
- done is never asserted twice for one word, and is 0 in every cycle other than the one after the last consume.
- Gaps in en of any length are legal mid-word; bit order is unaffected.

Decomposition:
- Shared package piso_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - localparam DEFAULT_WIDTH=8;
  - a function cnt_width(w) returning $clog2(w+1).
- One natural sub-module: piso_bit_counter. It is a loadable up-counter with clear, increment enable, and a terminal flag (cnt==WIDTH-1). The top module holds the FSM and shift register.

Test Plan:
1. Reset, then check outputs -> load_ready=1, busy=0, serial_out=0, done=0. Assert reset mid-SHIFT -> IDLE next cycle, no done pulse.
2. Load 8'hA5, en=1 continuously -> serial_out sequence 1,0,1,0,0,1,0,1 over cycles N+1..N+8; done pulse at N+9; load_ready back at N+9.
3. Loopback to Shift_Registers (receiver en=shift_en_out, serial_in=serial_out), send 8'h3C -> receiver Q==8'h3C on the cycle done=1.
4. Load 8'hF0 with en toggling (1,0,0,1,...) -> bits held during en=0 cycles; exactly 8 consumes; done once.
5. load_valid held high throughout, words 8'h01 then 8'h80 -> second accepted at edge N+9; receiver reads 8'h01 then 8'h80; load_valid ignored while busy.
6. LSB_FIRST=0, load 8'h81 -> first bit 1, then six 0s, last 1; with data 8'h40 first bit 0, second 1.
